// File: rtl/pipeline_wb_stage_if.sv
// Bundle of MEM->WB stage inputs and write-back outputs for pipeline_wb_stage.
// The stage has no back-pressure: stall/flush are pipeline controls, and inputs are sampled every unstalled edge.
interface pipeline_wb_stage_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              stall;
    logic              flush;
    logic              in_valid;
    logic              in_RegWrite;
    logic [1:0]        in_RegDst;
    logic [1:0]        in_MemtoReg;
    logic [REG_AW-1:0] in_WrReg;
    logic [DATA_W-1:0] in_inA;
    logic [DATA_W-1:0] in_inB;
    logic [DATA_W-1:0] in_PC;
    logic [2:0]        in_LoadType;
    logic [1:0]        in_ByteOff;
    logic [DATA_W-1:0] WB_out;
    logic [REG_AW-1:0] WB_Destiny;
    logic              WB_we;
    logic              WB_valid;
    logic [31:0]       retire_cnt;

    modport master (
        output stall, flush, in_valid, in_RegWrite, in_RegDst, in_MemtoReg, in_WrReg,
               in_inA, in_inB, in_PC, in_LoadType, in_ByteOff,
        input  WB_out, WB_Destiny, WB_we, WB_valid, retire_cnt
    );

    modport slave (
        input  stall, flush, in_valid, in_RegWrite, in_RegDst, in_MemtoReg, in_WrReg,
               in_inA, in_inB, in_PC, in_LoadType, in_ByteOff,
        output WB_out, WB_Destiny, WB_we, WB_valid, retire_cnt
    );
endinterface

// File: rtl/pipeline_wb_stage.sv
// Write-back pipeline stage: one register of MEM results, result mux, destination select, retire counter.
// Optional macro WB_LOAD_EXT_EN enables byte/halfword load extraction and sign/zero extension.
module pipeline_wb_stage #(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int LINK_REG = 31
) (
    input  logic               clk,
    input  logic               reset,
    pipeline_wb_stage_if.slave wb
);
    localparam logic [REG_AW-1:0] LINK_IDX = REG_AW'(LINK_REG);

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic [1:0]        reg_dst;
        logic [1:0]        memto_reg;
        logic [REG_AW-1:0] wr_reg;
        logic [DATA_W-1:0] in_a;
        logic [DATA_W-1:0] in_b;
        logic [DATA_W-1:0] pc;
        logic [2:0]        load_type;
        logic [1:0]        byte_off;
    } stage_t;

    stage_t            stage_q, stage_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0] load_data;
    logic [REG_AW-1:0] dest;

    // Flush wins over stall; a flush only drops the valid bit, fields stay for debug visibility.
    always_comb begin
        stage_d = stage_q;
        cnt_d   = cnt_q;
        if (wb.flush) begin
            stage_d.valid = 1'b0;
        end else if (!wb.stall) begin
            stage_d.valid     = wb.in_valid;
            stage_d.reg_write = wb.in_RegWrite;
            stage_d.reg_dst   = wb.in_RegDst;
            stage_d.memto_reg = wb.in_MemtoReg;
            stage_d.wr_reg    = wb.in_WrReg;
            stage_d.in_a      = wb.in_inA;
            stage_d.in_b      = wb.in_inB;
            stage_d.pc        = wb.in_PC;
            stage_d.load_type = wb.in_LoadType;
            stage_d.byte_off  = wb.in_ByteOff;
        end
        if (stage_q.valid && !wb.stall) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_q <= '0;
            cnt_q   <= '0;
        end else begin
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef WB_LOAD_EXT_EN
    logic [DATA_W-1:0] byte_shift, half_shift;

    always_comb begin
        byte_shift = stage_q.in_b >> {stage_q.byte_off, 3'b000};
        half_shift = stage_q.in_b >> {stage_q.byte_off[1], 4'b0000};
        case (stage_q.load_type)
            3'd1:    load_data = {{(DATA_W-8){byte_shift[7]}}, byte_shift[7:0]};
            3'd2:    load_data = {{(DATA_W-8){1'b0}}, byte_shift[7:0]};
            3'd3:    load_data = {{(DATA_W-16){half_shift[15]}}, half_shift[15:0]};
            3'd4:    load_data = {{(DATA_W-16){1'b0}}, half_shift[15:0]};
            default: load_data = stage_q.in_b;
        endcase
    end
`else
    assign load_data = stage_q.in_b;
`endif

    always_comb begin
        case (stage_q.memto_reg)
            2'd0:    wb.WB_out = stage_q.in_a;
            2'd1:    wb.WB_out = load_data;
            2'd2:    wb.WB_out = stage_q.pc;
            default: wb.WB_out = '0;
        endcase
    end

    assign dest          = (stage_q.reg_dst == 2'd2) ? LINK_IDX : stage_q.wr_reg;
    assign wb.WB_Destiny = dest;
    assign wb.WB_we      = stage_q.valid && stage_q.reg_write && (dest != '0);
    assign wb.WB_valid   = stage_q.valid;
    assign wb.retire_cnt = cnt_q;
endmodule

// File: tb/tb_pipeline_wb_stage.sv
// Self-checking bench for pipeline_wb_stage: scoreboard of expected write-back results, one task per scenario.
module tb_pipeline_wb_stage;
  localparam int DW = 32;
  localparam int AW = 5;

  typedef struct packed {
    logic [DW-1:0] out;
    logic [AW-1:0] dest;
    logic          we;
    logic          valid;
  } exp_t;
  localparam int EW = $bits(exp_t);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipeline_wb_stage_if #(.DATA_W(DW), .REG_AW(AW)) bus ();
  pipeline_wb_stage #(.DATA_W(DW), .REG_AW(AW), .LINK_REG(31)) dut (
    .clk(clk), .reset(reset), .wb(bus)
  );

  logic [EW-1:0] exp_q[$];
  int            checks = 0;
  int            errors = 0;
  logic [31:0]   exp_cnt = '0;
  logic          held_valid = 1'b0;

  function automatic logic [DW-1:0] model_load(input logic [DW-1:0] b, input logic [2:0] lt,
                                               input logic [1:0] bo);
    logic [7:0]  by;
    logic [15:0] hw;
    case (bo)
      2'd0: by = b[7:0];
      2'd1: by = b[15:8];
      2'd2: by = b[23:16];
      default: by = b[31:24];
    endcase
    hw = bo[1] ? b[31:16] : b[15:0];
`ifdef WB_LOAD_EXT_EN
    if (lt == 3'd1) return {{24{by[7]}}, by};
    if (lt == 3'd2) return {24'h0, by};
    if (lt == 3'd3) return {{16{hw[15]}}, hw};
    if (lt == 3'd4) return {16'h0, hw};
`endif
    return b;
  endfunction

  // Drive one instruction onto the inputs; optionally queue its modelled result.
  task automatic drive(input logic v, input logic rw, input logic [1:0] rd, input logic [1:0] mtr,
                       input logic [AW-1:0] wr, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] pc, input logic [2:0] lt, input logic [1:0] bo,
                       input logic push);
    exp_t e;
    bus.in_valid = v; bus.in_RegWrite = rw; bus.in_RegDst = rd; bus.in_MemtoReg = mtr;
    bus.in_WrReg = wr; bus.in_inA = a; bus.in_inB = b; bus.in_PC = pc;
    bus.in_LoadType = lt; bus.in_ByteOff = bo;
    e.dest  = (rd == 2'd2) ? 5'd31 : wr;
    e.out   = (mtr == 2'd0) ? a : (mtr == 2'd1) ? model_load(b, lt, bo) : (mtr == 2'd2) ? pc : '0;
    e.we    = v && rw && (e.dest != 5'd0);
    e.valid = v;
    if (push) exp_q.push_back(e);
  endtask

  // Advance one edge, updating the reference count/valid model, then sample away from the edge.
  task automatic step();
    @(posedge clk);
    if (!reset) begin
      held_valid = 1'b0;
      exp_cnt    = '0;
    end else begin
      if (held_valid && !bus.stall) exp_cnt = exp_cnt + 32'd1;
      if (bus.flush) held_valid = 1'b0;
      else if (!bus.stall) held_valid = bus.in_valid;
    end
    #1;
  endtask

  task automatic check_pop(input string name, input logic full);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, nothing to compare", name);
      return;
    end
    e = exp_q.pop_front();
    if (bus.WB_valid !== e.valid || bus.WB_we !== e.we ||
        (full && (bus.WB_out !== e.out || bus.WB_Destiny !== e.dest))) begin
      errors++;
      $display("FAIL %s: got out=%h dest=%0d we=%b valid=%b, expected out=%h dest=%0d we=%b valid=%b",
               name, bus.WB_out, bus.WB_Destiny, bus.WB_we, bus.WB_valid, e.out, e.dest, e.we, e.valid);
    end
  endtask

  task automatic check_cnt(input string name);
    checks++;
    if (bus.retire_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL %s: retire_cnt got %h expected %h", name, bus.retire_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
    drive(1, 1, 2'd2, 2'd2, 5'd7, 32'hDEAD_BEEF, 32'h1111_2222, 32'h3333_4444, 3'd0, 2'd0, 0);
    repeat (3) step();
    exp_q.push_back({32'h0, 5'd0, 1'b0, 1'b0});
    check_pop("reset_outputs", 1);
    check_cnt("reset_cnt");
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 2'd0, 2'd0, 5'd0, 0, 0, 0, 3'd0, 2'd0, 0);
  endtask

  task automatic test_alu_write();
    drive(1, 1, 2'd0, 2'd0, 5'd8, 32'h1234_5678, 32'h0, 32'h0, 3'd0, 2'd0, 1);
    step();
    check_pop("alu_write", 1);
    drive(0, 0, 2'd0, 2'd0, 5'd0, 0, 0, 0, 3'd0, 2'd0, 1);
    step();
    check_pop("alu_bubble", 0);
    check_cnt("alu_retire_one");
  endtask

  task automatic test_dest_select();
    drive(1, 1, 2'd2, 2'd2, 5'd3, 32'h0, 32'h0, 32'h0040_0010, 3'd0, 2'd0, 1);
    step(); check_pop("link_pc", 1);
    drive(1, 1, 2'd0, 2'd0, 5'd0, 32'hCAFE_0001, 32'h0, 32'h0, 3'd0, 2'd0, 1);
    step(); check_pop("r0_no_we", 1);
    drive(1, 1, 2'd1, 2'd3, 5'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd0, 2'd0, 1);
    step(); check_pop("zero_sel", 1);
    drive(1, 0, 2'd3, 2'd0, 5'd12, 32'h0BAD_F00D, 32'h0, 32'h0, 3'd0, 2'd0, 1);
    step(); check_pop("no_regwrite", 1);
    check_cnt("dest_cnt");
  endtask

  task automatic test_load_ext();
    logic [DW-1:0] b;
    b = 32'h80FF_7F01;
`ifdef WB_LOAD_EXT_EN
    drive(1, 1, 2'd0, 2'd1, 5'd4, 0, b, 0, 3'd1, 2'd3, 0); exp_q.push_back({32'hFFFF_FF80, 5'd4, 1'b1, 1'b1});
    step(); check_pop("lb_off3", 1);
    drive(1, 1, 2'd0, 2'd1, 5'd4, 0, b, 0, 3'd2, 2'd1, 0); exp_q.push_back({32'h0000_007F, 5'd4, 1'b1, 1'b1});
    step(); check_pop("lbu_off1", 1);
    drive(1, 1, 2'd0, 2'd1, 5'd4, 0, b, 0, 3'd3, 2'd2, 0); exp_q.push_back({32'hFFFF_80FF, 5'd4, 1'b1, 1'b1});
    step(); check_pop("lh_off2", 1);
`else
    drive(1, 1, 2'd0, 2'd1, 5'd4, 0, b, 0, 3'd1, 2'd3, 0); exp_q.push_back({32'h80FF_7F01, 5'd4, 1'b1, 1'b1});
    step(); check_pop("lb_off3_raw", 1);
    drive(1, 1, 2'd0, 2'd1, 5'd4, 0, b, 0, 3'd2, 2'd1, 0); exp_q.push_back({32'h80FF_7F01, 5'd4, 1'b1, 1'b1});
    step(); check_pop("lbu_off1_raw", 1);
    drive(1, 1, 2'd0, 2'd1, 5'd4, 0, b, 0, 3'd3, 2'd2, 0); exp_q.push_back({32'h80FF_7F01, 5'd4, 1'b1, 1'b1});
    step(); check_pop("lh_off2_raw", 1);
`endif
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 2'd0, 2'd1, 5'd6, 0, b, 0, i[2:0], i[1:0] ^ 2'd1, 1);
      step(); check_pop($sformatf("load_lt%0d", i), 1);
    end
    check_cnt("load_cnt");
  endtask

  task automatic test_stall_flush();
    drive(1, 1, 2'd0, 2'd0, 5'd17, 32'hA5A5_0017, 0, 0, 3'd0, 2'd0, 1);
    step(); check_pop("pre_stall", 1);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 2'd0, 2'd0, 5'd20 + 5'(i), 32'h5555_0000 + i, 0, 0, 3'd0, 2'd0, 0);
      exp_q.push_back({32'hA5A5_0017, 5'd17, 1'b1, 1'b1});
      step(); check_pop($sformatf("stall_hold%0d", i), 1);
      check_cnt($sformatf("stall_cnt%0d", i));
    end
    bus.flush = 1'b1;
    exp_q.push_back({32'h0, 5'd0, 1'b0, 1'b0});
    step(); check_pop("flush_bubble", 0);
    check_cnt("flush_cnt");
    bus.stall = 1'b0; bus.flush = 1'b0;
    drive(0, 0, 2'd0, 2'd0, 5'd0, 0, 0, 0, 3'd0, 2'd0, 1);
    step(); check_pop("post_flush", 0);
    check_cnt("post_flush_cnt");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), $urandom, $urandom, $urandom,
            3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 1);
      step(); check_pop($sformatf("b2b_%0d", i), 1);
    end
    check_cnt("b2b_cnt");
  endtask

  task automatic test_wrap();
    drive(1, 1, 2'd0, 2'd0, 5'd1, 32'h1, 0, 0, 3'd0, 2'd0, 1);
    step(); check_pop("wrap_a", 1);
    force dut.cnt_q = 32'hFFFF_FFFE;
    #1 release dut.cnt_q;
    exp_cnt = 32'hFFFF_FFFE;
    drive(1, 1, 2'd0, 2'd0, 5'd2, 32'h2, 0, 0, 3'd0, 2'd0, 1);
    step(); check_pop("wrap_b", 1);
    check_cnt("wrap_max");
    drive(0, 0, 2'd0, 2'd0, 5'd0, 0, 0, 0, 3'd0, 2'd0, 1);
    step(); check_pop("wrap_bubble", 0);
    check_cnt("wrap_zero");
  endtask

  task automatic test_async_reset();
    drive(1, 1, 2'd0, 2'd0, 5'd10, 32'h0000_BEEF, 0, 0, 3'd0, 2'd0, 1);
    step(); check_pop("pre_reset_we", 1);
    drive(1, 1, 2'd0, 2'd0, 5'd11, 32'h0000_C0DE, 0, 0, 3'd0, 2'd0, 1);
    step(); check_pop("pre_reset_we2", 1);
    #1 reset = 1'b0;
    #1;
    exp_q.delete();
    held_valid = 1'b0; exp_cnt = '0;
    exp_q.push_back({32'h0, 5'd0, 1'b0, 1'b0});
    check_pop("async_reset_outputs", 1);
    check_cnt("async_reset_cnt");
    @(negedge clk);
    reset = 1'b1;
    drive(1, 1, 2'd0, 2'd0, 5'd13, 32'h1357_9BDF, 0, 0, 3'd0, 2'd0, 1);
    step(); check_pop("resume_capture", 1);
    check_cnt("resume_cnt");
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_dest_select();
    test_load_ext();
    test_stall_flush();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_wb_stage.md
PIPELINE_WB_STAGE -- requirements
Module: pipeline_wb_stage

Interface
REQ-001 Parameter DATA_W, 32, datapath width in bits (multiple of 8, >=16).
REQ-002 Parameter REG_AW, 5, register-address width.
REQ-003 Parameter LINK_REG, 31, destination index forced when RegDst==2.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 stall  in  1  hold the stage register.
REQ-007 flush  in  1  load a bubble into the stage register.
REQ-008 in_valid  in  1  incoming MEM-stage instruction is valid.
REQ-009 in_RegWrite  in  1  instruction writes the register file.
REQ-010 in_RegDst  in  2  2 selects LINK_REG; other values select in_WrReg.
REQ-011 in_MemtoReg  in  2  0 ALU, 1 memory, 2 PC, 3 zero.
REQ-012 in_WrReg  in  REG_AW  destination register from earlier stages.
REQ-013 in_inA / in_inB / in_PC  in  DATA_W each  ALU result / memory read data / link value.
REQ-014 in_LoadType  in  3  0 word, 1 byte signed, 2 byte unsigned, 3 half signed, 4 half unsigned.
REQ-015 in_ByteOff  in  2  low address bits of the load.
REQ-016 WB_out  out  DATA_W  write-back data.
REQ-017 WB_Destiny  out  REG_AW  write-back register index.
REQ-018 WB_we  out  1  register-file write enable.
REQ-019 WB_valid  out  1  stage holds a valid instruction.
REQ-020 retire_cnt  out  32  count of retired valid instructions.

Function
REQ-021 Stage register captures all in_* fields on a clock edge when stall=0 and flush=0.
REQ-022 flush=1 clears the stored valid bit on the next edge; flush has priority over stall.
REQ-023 stall=1 with flush=0 holds all stored fields unchanged.
REQ-024 Latency is one cycle: inputs at edge N are reflected on the outputs after edge N.
REQ-025 WB_out is combinational from stored fields: MemtoReg 0 selects inA, 1 the load-formatted inB, 2 PC, 3 zero.
REQ-026 WB_Destiny equals LINK_REG when stored RegDst==2; otherwise it equals stored WrReg.
REQ-027 WB_we = valid AND RegWrite AND (WB_Destiny != 0).
REQ-028 WB_out and WB_Destiny drive their computed values even when WB_we=0.
REQ-029 retire_cnt increments by 1 on each edge where the stage holds valid=1 and stall=0; it wraps from 0xFFFFFFFF to 0.
REQ-030 A stalled instruction is counted exactly once.
REQ-031 Undefined LoadType values 5-7 behave as word.

Reset
REQ-032 While reset=0: valid=0 and all stored fields are 0, so WB_we=0, WB_valid=0, WB_out=0, WB_Destiny=0, and retire_cnt=0.
REQ-033 Reset asserted mid-operation clears state immediately, without waiting for a clock edge.
REQ-034 Stage capture resumes on the first edge after reset deasserts.

Configuration
REQ-035 Macro WB_LOAD_EXT_EN.
- Defined: when MemtoReg==1, inB is formatted per LoadType.
  - Byte lane = ByteOff; halfword lane = ByteOff[1]; lane 0 is the least-significant lane.
  - Signed types sign-extend to DATA_W; unsigned types zero-extend.
- Undefined: LoadType and ByteOff are ignored, and inB passes unmodified.

Verification
REQ-036 Reset held low, then released; one valid ALU write (inA=0x12345678, WrReg=8, RegWrite=1) -> WB_out=0x12345678, WB_Destiny=8, WB_we=1 one cycle later; retire_cnt=1 after the next edge.
REQ-037 RegDst=2, MemtoReg=2, PC=0x00400010 -> WB_Destiny=31, WB_out=0x00400010; WrReg=0 with RegDst=0 -> WB_we=0.
REQ-038 Stall for 3 cycles, then assert stall and flush together -> fields held during the stall; the flush produces WB_valid=0 and WB_we=0; retire_cnt is unchanged by the bubble.
REQ-039 With WB_LOAD_EXT_EN, inB=0x80FF7F01: LoadType 1, ByteOff 3 -> 0xFFFFFF80; LoadType 2, ByteOff 1 -> 0x0000007F; LoadType 3, ByteOff 2 -> 0xFFFF80FF. Without the macro, all three cases give 0x80FF7F01.
REQ-040 retire_cnt is forced near 0xFFFFFFFE via 2 retires after preload (bench backdoor) -> wraps to 0x00000000.
REQ-041 reset pulsed low mid-cycle while WB_we=1 -> WB_we=0 and retire_cnt=0 before the next clock edge.
